// File: rtl/corefifo_sync_pkg.sv
// -----------------------------------------------------------------------------
// corefifo_sync_pkg
// Shared types and elaboration-time helpers for the single-clock COREFIFO
// controller: parameter legality checks and the occupancy counter width.
// -----------------------------------------------------------------------------
package corefifo_sync_pkg;

    localparam int unsigned PIPE_MIN = 1;
    localparam int unsigned PIPE_MAX = 2;

    // Registered status flags kept together so they reset and update as one.
    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

    // RAM read latency must be 1 (non-pipelined) or 2 (pipelined).
    function automatic bit pipe_ok(input int unsigned pipe);
        return (pipe >= PIPE_MIN) && (pipe <= PIPE_MAX);
    endfunction

    function automatic bit afull_ok(input int unsigned afull_val, input int unsigned awidth);
        return afull_val <= (32'd1 << awidth);
    endfunction

    function automatic bit aempty_ok(input int unsigned aempty_val, input int unsigned awidth);
        return aempty_val < (32'd1 << awidth);
    endfunction

    // Occupancy runs 0..DEPTH inclusive, so one bit wider than the address.
    function automatic int unsigned cnt_width(input int unsigned awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/corefifo_sync_flags.sv
// -----------------------------------------------------------------------------
// corefifo_sync_flags
// Occupancy counter and status flags. Accept decisions come from the
// registered flags only, so no status output depends combinationally on
// WE/RE.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   we_i, re_i               raw write/read requests
//   wacc_o, racc_o           accepted write/read (combinational, gated by reset)
//   full_o, empty_o,
//   afull_o, aempty_o        registered status flags
//   overflow_o, underflow_o  registered one-cycle rejection pulses
//   count_o                  registered occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module corefifo_sync_flags
    import corefifo_sync_pkg::*;
#(
    parameter int unsigned AWIDTH     = 7,
    parameter int unsigned AFULL_VAL  = 120,
    parameter int unsigned AEMPTY_VAL = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_i,
    input  logic                         re_i,
    output logic                         wacc_o,
    output logic                         racc_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         afull_o,
    output logic                         aempty_o,
    output logic                         overflow_o,
    output logic                         underflow_o,
    output logic [cnt_width(AWIDTH)-1:0] count_o
);

    localparam int unsigned CW = cnt_width(AWIDTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(2 ** AWIDTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_VAL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_VAL);

    fifo_flags_t      flags_q, flags_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wacc, racc;

    // A full FIFO rejects writes even when a read drains it in the same cycle,
    // and an empty one rejects reads even alongside a write.
    assign wacc = we_i && !flags_q.full  && !rst_i;
    assign racc = re_i && !flags_q.empty && !rst_i;

    // Next occupancy and the flags derived from it.
    always_comb begin
        count_d        = count_q + CW'(wacc) - CW'(racc);
        flags_d.full   = (count_d == DEPTH_C);
        flags_d.empty  = (count_d == '0);
        flags_d.afull  = (count_d >= AFULL_C);
        flags_d.aempty = (count_d <= AEMPTY_C);
        ovf_d          = we_i && flags_q.full;
        udf_d          = re_i && flags_q.empty;
    end

    // Status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            flags_q <= '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign wacc_o      = wacc;
    assign racc_o      = racc;
    assign full_o      = flags_q.full;
    assign empty_o     = flags_q.empty;
    assign afull_o     = flags_q.afull;
    assign aempty_o    = flags_q.aempty;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;
    assign count_o     = count_q;

endmodule

// File: rtl/corefifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// corefifo_sync_ctrl
// Single-clock FIFO controller in front of the LSRAM wrapper. Owns the
// read/write pointers and the read-valid pipeline; flags and occupancy live
// in corefifo_sync_flags.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   we_i, data_i              write request and data
//   re_i                      read request
//   q_o, dvld_o               read data (straight from RAM) and its valid strobe
//   full_o, empty_o,
//   afull_o, aempty_o         registered status flags
//   overflow_o, underflow_o   registered rejection pulses
//   wrcnt_o                   registered occupancy 0..DEPTH
//   mem_w*_o, mem_r*_o        wrapper write/read port (combinational)
//   mem_rdata_i               wrapper read data
// -----------------------------------------------------------------------------
module corefifo_sync_ctrl
    import corefifo_sync_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned AWIDTH     = 7,
    parameter int unsigned AFULL_VAL  = 120,
    parameter int unsigned AEMPTY_VAL = 8,
    parameter int unsigned PIPE       = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              re_i,
    output logic [WIDTH-1:0]  q_o,
    output logic              dvld_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              afull_o,
    output logic              aempty_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic [AWIDTH:0]   wrcnt_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    output logic [AWIDTH-1:0] mem_waddr_o,
    output logic              mem_wen_o,
    output logic [AWIDTH-1:0] mem_raddr_o,
    output logic              mem_ren_o,
    input  logic [WIDTH-1:0]  mem_rdata_i
);

    // Reject illegal parameterisations at elaboration.
    if (!pipe_ok(PIPE)) begin : g_bad_pipe
        $error("corefifo_sync_ctrl: PIPE must be 1 or 2");
    end
    if (!afull_ok(AFULL_VAL, AWIDTH)) begin : g_bad_afull
        $error("corefifo_sync_ctrl: AFULL_VAL exceeds DEPTH");
    end
    if (!aempty_ok(AEMPTY_VAL, AWIDTH)) begin : g_bad_aempty
        $error("corefifo_sync_ctrl: AEMPTY_VAL must be below DEPTH");
    end

    logic              wacc, racc;
    logic [AWIDTH-1:0] wptr_q, wptr_d;
    logic [AWIDTH-1:0] rptr_q, rptr_d;
    logic [PIPE-1:0]   dv_q, dv_d;

    corefifo_sync_flags #(
        .AWIDTH     (AWIDTH),
        .AFULL_VAL  (AFULL_VAL),
        .AEMPTY_VAL (AEMPTY_VAL)
    ) u_flags (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .we_i        (we_i),
        .re_i        (re_i),
        .wacc_o      (wacc),
        .racc_o      (racc),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .afull_o     (afull_o),
        .aempty_o    (aempty_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .count_o     (wrcnt_o)
    );

    // Pointers wrap naturally at DEPTH; the valid pipe shifts in each accepted
    // read so DVLD lines up with the RAM's PIPE-cycle read latency.
    always_comb begin
        wptr_d = wptr_q + AWIDTH'(wacc);
        rptr_d = rptr_q + AWIDTH'(racc);
        dv_d   = PIPE'({dv_q, racc});
    end

    // Pointer and valid-pipe registers; reset drops reads in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dv_q   <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            dv_q   <= dv_d;
        end
    end

    assign mem_wen_o   = wacc;
    assign mem_waddr_o = wptr_q;
    assign mem_wdata_o = data_i;
    assign mem_ren_o   = racc;
    assign mem_raddr_o = rptr_q;
    assign q_o         = mem_rdata_i;
    assign dvld_o      = dv_q[PIPE-1];

endmodule
